// File: rtl/cam_pipe_match_if.sv
// Port bundle for cam_pipe_match: write/invalidate/flush update ports, search
// request ports and the registered search results.
interface cam_pipe_match_if #(
  parameter int DEPTH         = 32,
  parameter int INDEX         = 5,
  parameter int WIDTH         = 8,
  parameter int NUM_WR_PORTS  = 4,
  parameter int NUM_RD_PORTS  = 4,
  parameter int NUM_INV_PORTS = 2
);
  logic [NUM_WR_PORTS-1:0]                 wrEn_i;
  logic [NUM_WR_PORTS-1:0][INDEX-1:0]      addrWr_i;
  logic [NUM_WR_PORTS-1:0][WIDTH-1:0]      dataWr_i;
  logic [NUM_INV_PORTS-1:0]                invEn_i;
  logic [NUM_INV_PORTS-1:0][INDEX-1:0]     addrInv_i;
  logic                                    flush_i;
  logic [NUM_RD_PORTS-1:0]                 searchEn_i;
  logic [NUM_RD_PORTS-1:0][WIDTH-1:0]      tag_i;
  logic [NUM_RD_PORTS-1:0][DEPTH-1:0]      vect_o;
  logic [NUM_RD_PORTS-1:0]                 hit_o;
  logic [NUM_RD_PORTS-1:0][INDEX-1:0]      hitIdx_o;
  logic [NUM_RD_PORTS-1:0]                 multiHit_o;
  logic                                    ramReady_o;

  modport master (
    output wrEn_i, addrWr_i, dataWr_i, invEn_i, addrInv_i, flush_i,
           searchEn_i, tag_i,
    input  vect_o, hit_o, hitIdx_o, multiHit_o, ramReady_o
  );

  modport slave (
    input  wrEn_i, addrWr_i, dataWr_i, invEn_i, addrInv_i, flush_i,
           searchEn_i, tag_i,
    output vect_o, hit_o, hitIdx_o, multiHit_o, ramReady_o
  );
endinterface

// File: rtl/cam_pipe_match.sv
// Multi-port valid-qualified CAM with post-reset init sweep and registered lookup.
// Define CAM_PIPE_WR_BYPASS_EN to let searches see same-cycle updates (write-first).
module cam_pipe_match #(
  parameter int DEPTH         = 32,
  parameter int INDEX         = 5,
  parameter int WIDTH         = 8,
  parameter int NUM_WR_PORTS  = 4,
  parameter int NUM_RD_PORTS  = 4,
  parameter int NUM_INV_PORTS = 2,
  parameter int RESET_SEQ     = 0,
  parameter int SEQ_START     = 0,
  parameter int INIT_VALID    = 0
) (
  input  logic             clk,
  input  logic             reset,
  cam_pipe_match_if.slave  bus
);
  typedef enum logic [1:0] {RESET, INIT, READY} state_t;

  state_t              state;
  logic [INDEX-1:0]    init_cnt;
  logic                ram_ready;
  logic [WIDTH-1:0]    tag_q   [DEPTH];
  logic [WIDTH-1:0]    tag_nxt [DEPTH];
  logic [WIDTH-1:0]    cmp_tag [DEPTH];
  logic [DEPTH-1:0]    valid_q;
  logic [DEPTH-1:0]    valid_nxt;
  logic [DEPTH-1:0]    cmp_valid;
  logic                init_wr;
  logic                ready_up;

  logic [NUM_RD_PORTS-1:0][DEPTH-1:0] match;
  logic [NUM_RD_PORTS-1:0]            hit_c;
  logic [NUM_RD_PORTS-1:0][INDEX-1:0] idx_c;
  logic [NUM_RD_PORTS-1:0]            multi_c;

  logic [NUM_RD_PORTS-1:0][DEPTH-1:0] vect_p1;
  logic [NUM_RD_PORTS-1:0]            hit_p1;
  logic [NUM_RD_PORTS-1:0][INDEX-1:0] idx_p1;
  logic [NUM_RD_PORTS-1:0]            multi_p1;

  // The first reset-free cycle already writes entry 0, so ready lands DEPTH+1 cycles after release.
  assign init_wr  = (state != READY) && !reset;
  assign ready_up = (state == READY) && !reset;

  // Array next state: init sweep, else flush/invalidate then writes (writes override both).
  always_comb begin
    tag_nxt   = tag_q;
    valid_nxt = valid_q;
    for (int k = 0; k < DEPTH; k++) begin
      if (init_wr && init_cnt == INDEX'(k)) begin
        tag_nxt[k]   = (RESET_SEQ != 0) ? WIDTH'(SEQ_START + k) : '0;
        valid_nxt[k] = (INIT_VALID != 0);
      end else if (ready_up) begin
        if (bus.flush_i) begin
          valid_nxt[k] = 1'b0;
        end else begin
          for (int i = 0; i < NUM_INV_PORTS; i++)
            if (bus.invEn_i[i] && bus.addrInv_i[i] == INDEX'(k)) valid_nxt[k] = 1'b0;
        end
        for (int w = 0; w < NUM_WR_PORTS; w++) begin
          if (bus.wrEn_i[w] && bus.addrWr_i[w] == INDEX'(k)) begin
            tag_nxt[k]   = bus.dataWr_i[w];
            valid_nxt[k] = 1'b1;
          end
        end
      end
    end
  end

`ifdef CAM_PIPE_WR_BYPASS_EN
  always_comb cmp_tag = tag_nxt;
  assign cmp_valid = valid_nxt;
`else
  always_comb cmp_tag = tag_q;
  assign cmp_valid = valid_q;
`endif

  always_comb begin
    match   = '0;
    hit_c   = '0;
    idx_c   = '0;
    multi_c = '0;
    for (int p = 0; p < NUM_RD_PORTS; p++) begin
      for (int k = 0; k < DEPTH; k++) begin
        match[p][k] = ready_up && bus.searchEn_i[p] && cmp_valid[k] &&
                      (cmp_tag[k] == bus.tag_i[p]);
        if (match[p][k]) begin
          if (hit_c[p]) multi_c[p] = 1'b1;
          else          idx_c[p]   = INDEX'(k);
          hit_c[p] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    tag_q <= tag_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RESET;
      init_cnt  <= '0;
      valid_q   <= '0;
      ram_ready <= 1'b0;
    end else begin
      valid_q <= valid_nxt;
      case (state)
        RESET, INIT: begin
          if (init_cnt == INDEX'(DEPTH - 1)) begin
            state     <= READY;
            ram_ready <= 1'b1;
          end else begin
            state    <= INIT;
            init_cnt <= init_cnt + 1'b1;
          end
        end
        default: state <= READY;
      endcase
    end
  end

  // Stage p0 -> p1: registered search results.
  always_ff @(posedge clk) begin
    if (reset) begin
      vect_p1  <= '0;
      hit_p1   <= '0;
      idx_p1   <= '0;
      multi_p1 <= '0;
    end else begin
      vect_p1  <= match;
      hit_p1   <= hit_c;
      idx_p1   <= idx_c;
      multi_p1 <= multi_c;
    end
  end

  assign bus.vect_o     = vect_p1;
  assign bus.hit_o      = hit_p1;
  assign bus.hitIdx_o   = idx_p1;
  assign bus.multiHit_o = multi_p1;
  assign bus.ramReady_o = ram_ready;
endmodule

// File: tb/tb_cam_pipe_match.sv
// Directed bench for cam_pipe_match: init sweep, reset mid-init, flush, multi-hit,
// invalidate, write collision and same-cycle write/search visibility.
module tb_cam_pipe_match;
  localparam int DEPTH = 32, INDEX = 5, WIDTH = 8;
  localparam int NWR = 4, NRD = 4, NINV = 2;

  logic clk = 1'b0;
  logic reset;
  int   n_chk  = 0;
  int   n_pass = 0;
  int   n;

  cam_pipe_match_if #(.DEPTH(DEPTH), .INDEX(INDEX), .WIDTH(WIDTH),
    .NUM_WR_PORTS(NWR), .NUM_RD_PORTS(NRD), .NUM_INV_PORTS(NINV)) bus ();

  cam_pipe_match #(.DEPTH(DEPTH), .INDEX(INDEX), .WIDTH(WIDTH),
    .NUM_WR_PORTS(NWR), .NUM_RD_PORTS(NRD), .NUM_INV_PORTS(NINV),
    .RESET_SEQ(1), .SEQ_START(5), .INIT_VALID(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic clear_in();
    bus.wrEn_i = '0; bus.addrWr_i = '0; bus.dataWr_i = '0;
    bus.invEn_i = '0; bus.addrInv_i = '0; bus.flush_i = 1'b0;
    bus.searchEn_i = '0; bus.tag_i = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int p, input logic [INDEX-1:0] a, input logic [WIDTH-1:0] d);
    bus.wrEn_i[p] = 1'b1; bus.addrWr_i[p] = a; bus.dataWr_i[p] = d;
  endtask

  task automatic inv(input int p, input logic [INDEX-1:0] a);
    bus.invEn_i[p] = 1'b1; bus.addrInv_i[p] = a;
  endtask

  task automatic search(input int p, input logic [WIDTH-1:0] t);
    bus.searchEn_i[p] = 1'b1; bus.tag_i[p] = t;
  endtask

  initial begin
    clear_in();
    reset = 1'b1;
    repeat (3) step();
    check("rst_ready", 64'(bus.ramReady_o), 64'd0);
    check("rst_hit",   64'(bus.hit_o), 64'd0);
    check("rst_vect",  64'(bus.vect_o), 64'd0);
    check("rst_idx",   64'(bus.hitIdx_o), 64'd0);
    check("rst_multi", 64'(bus.multiHit_o), 64'd0);

    // Init sweep: entry k gets tag 5+k, valid.
    reset = 1'b0;
    n = 0;
    while (!bus.ramReady_o && n < 40) begin
      if (n == 4) search(0, 8'd5);
      step();
      n++;
      if (n == 5) begin
        check("init_search_gated", 64'(bus.hit_o[0]), 64'd0);
        clear_in();
      end
    end
    check("init_latency", 64'(n), 64'd32);
    search(0, 8'd12);
    step();
    clear_in();
    check("init_hit",   64'(bus.hit_o[0]), 64'd1);
    check("init_idx",   64'(bus.hitIdx_o[0]), 64'd7);
    check("init_vect",  64'(bus.vect_o[0]), 64'h80);
    check("init_multi", 64'(bus.multiHit_o[0]), 64'd0);

    // Reset mid-init at sweep index 10.
    reset = 1'b1;
    step();
    check("reassert_ready", 64'(bus.ramReady_o), 64'd0);
    reset = 1'b0;
    repeat (10) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    n = 0;
    while (!bus.ramReady_o && n < 40) begin
      step();
      n++;
    end
    check("reinit_latency", 64'(n), 64'd32);
    search(1, 8'd36);
    step();
    clear_in();
    check("reinit_last_idx", 64'(bus.hitIdx_o[1]), 64'd31);

    // Flush with a same-cycle write and a cancelled invalidate.
    wr(0, 5'd6, 8'h55);
    inv(0, 5'd7);
    bus.flush_i = 1'b1;
    step();
    clear_in();
    search(0, 8'h55);
    search(1, 8'd12);
    search(2, 8'd5);
    bus.tag_i[3] = 8'h55;
    step();
    clear_in();
    check("flush_vect", 64'(bus.vect_o[0]), 64'h40);
    check("flush_idx",  64'(bus.hitIdx_o[0]), 64'd6);
    check("flush_miss1", 64'(bus.hit_o[1]), 64'd0);
    check("flush_miss2", 64'(bus.hit_o[2]), 64'd0);
    check("noen_hit",   64'(bus.hit_o[3]), 64'd0);
    check("noen_vect",  64'(bus.vect_o[3]), 64'd0);

    // Multi-hit.
    wr(0, 5'd4, 8'h3C);
    wr(1, 5'd9, 8'h3C);
    step();
    clear_in();
    search(0, 8'h3C);
    step();
    clear_in();
    check("multi_vect",  64'(bus.vect_o[0]), 64'h210);
    check("multi_hit",   64'(bus.hit_o[0]), 64'd1);
    check("multi_idx",   64'(bus.hitIdx_o[0]), 64'd4);
    check("multi_multi", 64'(bus.multiHit_o[0]), 64'd1);

    // Invalidate one of the two copies.
    inv(1, 5'd4);
    step();
    clear_in();
    search(2, 8'h3C);
    step();
    clear_in();
    check("inv_vect",  64'(bus.vect_o[2]), 64'h200);
    check("inv_idx",   64'(bus.hitIdx_o[2]), 64'd9);
    check("inv_multi", 64'(bus.multiHit_o[2]), 64'd0);

    // Write collision: port 3 wins, invalidate to the written address is ignored.
    wr(0, 5'd2, 8'h11);
    wr(3, 5'd2, 8'h22);
    inv(0, 5'd2);
    step();
    clear_in();
    search(0, 8'h22);
    search(1, 8'h11);
    step();
    clear_in();
    check("coll_vect", 64'(bus.vect_o[0]), 64'h4);
    check("coll_hit",  64'(bus.hit_o[0]), 64'd1);
    check("coll_lose", 64'(bus.hit_o[1]), 64'd0);

    // Same-cycle write and search.
    wr(2, 5'd1, 8'h7E);
    search(0, 8'h7E);
    step();
    clear_in();
`ifdef CAM_PIPE_WR_BYPASS_EN
    check("bypass_same", 64'(bus.hit_o[0]), 64'd1);
`else
    check("bypass_same", 64'(bus.hit_o[0]), 64'd0);
`endif
    search(0, 8'h7E);
    step();
    clear_in();
    check("bypass_next_hit", 64'(bus.hit_o[0]), 64'd1);
    check("bypass_next_idx", 64'(bus.hitIdx_o[0]), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/cam_pipe_match.md
# cam_pipe_match

Parametrised multi-port CAM with per-entry valid bits, a registered lookup stage and a priority encoder on every search port. It succeeds the static-config CAM used by the rename and issue structures. Additions over that block: valid-qualified matching, invalidate and flush ports, hit/index/multi-hit outputs, and a post-reset initialisation sweep that gates `ramReady_o`. It sits wherever tag lookup feeds a pipelined consumer: load/store disambiguation, wakeup, free-list lookup.

## Interface
- `DEPTH`, 32: number of entries.
- `INDEX`, 5: entry address width; must be at least clog2(DEPTH).
- `WIDTH`, 8: tag width.
- `NUM_WR_PORTS`, 4: write ports.
- `NUM_RD_PORTS`, 4: search ports.
- `NUM_INV_PORTS`, 2: per-entry invalidate ports.
- `RESET_SEQ`, 0: 1 loads tag `SEQ_START+k` into entry k during init; 0 loads 0.
- `SEQ_START`, 0: base value for sequential init.
- `INIT_VALID`, 0: valid value written to every entry during init.

Ports:
- `clk`  in  1  clock; one clock domain.
- `reset`  in  1  reset; synchronous and active-high.
- `wrEn_i`  in  NUM_WR_PORTS  write enables.
- `addrWr_i`  in  NUM_WR_PORTS×INDEX  write addresses.
- `dataWr_i`  in  NUM_WR_PORTS×WIDTH  write tags; a write also sets valid.
- `invEn_i`  in  NUM_INV_PORTS  invalidate enables.
- `addrInv_i`  in  NUM_INV_PORTS×INDEX  invalidate addresses.
- `flush_i`  in  1  clear all valid bits.
- `searchEn_i`  in  NUM_RD_PORTS  search request.
- `tag_i`  in  NUM_RD_PORTS×WIDTH  search tags.
- `vect_o`  out  NUM_RD_PORTS×DEPTH  registered match vector.
- `hit_o`  out  NUM_RD_PORTS  registered any-match.
- `hitIdx_o`  out  NUM_RD_PORTS×INDEX  registered lowest matching index.
- `multiHit_o`  out  NUM_RD_PORTS  registered: more than one entry matched.
- `ramReady_o`  out  1  high once initialisation is complete.

## Operation
- State machine with states RESET, INIT and READY.
  - `reset` high forces RESET: init counter = 0 and all valid bits = 0.
  - RESET to INIT on the first cycle `reset` is low.
  - INIT writes one entry per cycle (tag per `RESET_SEQ`, valid = `INIT_VALID`), index 0 up to DEPTH-1.
  - INIT to READY after the write to DEPTH-1.
  - READY holds until `reset`.
- Reset reasserted mid-INIT returns the machine to RESET and restarts the sweep from index 0.
- In RESET and INIT:
  - `wrEn_i`, `invEn_i`, `flush_i` and `searchEn_i` are ignored.
  - Search outputs register as 0.
- Entry k matches for port p when `valid[k]` is set and `tag[k]` equals `tag_i[p]`.
- `hitIdx_o` is the lowest-index match, or 0 when there is no hit.
- `multiHit_o` is set when the popcount of matches is greater than 1.
- Port with `searchEn_i` = 0: its outputs register as 0.
- Update priority within one cycle, highest first:
  1. `flush_i`: clears all valid bits and cancels that cycle's invalidates. Writes in the same cycle still land, with valid = 1.
  2. Writes: the highest-numbered port wins an address collision.
  3. Invalidates: ignored for any address also written in that cycle.
- No X on outputs in any state. Out-of-range addresses (at or above DEPTH) are dropped.

## Timing
- Writes, invalidates and flush update the array at the clock edge ending cycle N.
- Search presented in cycle N: results appear on outputs in cycle N+1 (one-cycle latency), registered.
- The search compares array state per the configuration below.
- Reset values:
  - `vect_o`, `hit_o`, `hitIdx_o`, `multiHit_o`: 0.
  - `ramReady_o`: 0.
- `ramReady_o` rises in the cycle after the last init write.
  - It rises exactly DEPTH+1 cycles after `reset` falls.
  - It is registered and glitch-free.
- A search issued in the same cycle `ramReady_o` first reads 1 is serviced normally.

## Configuration
- Macro: `CAM_PIPE_WR_BYPASS_EN`.
- Defined: a search in cycle N sees cycle N's writes, invalidates and flush (write-first). Same-cycle priority rules apply.
- Undefined: a search in cycle N compares pre-update state (read-first). Same-cycle writes are visible only to searches in N+1 or later.
- Neither mode changes output latency.

## Test plan
- Init:
  - Stimulus: DEPTH=32, `RESET_SEQ`=1, `SEQ_START`=5, `INIT_VALID`=1; release `reset`.
  - Expect: `ramReady_o`=0 for 32 cycles, then 1 in cycle 33. Search tag 12 gives hit=1, idx=7 one cycle later.
- Reset mid-INIT:
  - Stimulus: assert `reset` at init index 10, release.
  - Expect: sweep restarts at 0; `ramReady_o` rises 33 cycles after the second release.
- Multi-hit:
  - Stimulus: write tag 0x3C to entries 4 and 9; search 0x3C.
  - Expect: `vect_o`=bits 4 and 9, hit=1, idx=4, multiHit=1.
- Collision:
  - Stimulus: ports 0 and 3 write entry 2 with 0x11 and 0x22; invalidate entry 2 in the same cycle.
  - Expect: entry 2 holds 0x22 and is valid; search 0x11 misses.
- Flush:
  - Stimulus: fill entries, then assert flush with a write of 0x55 to entry 6.
  - Expect: only entry 6 remains valid; search of any other tag misses.
- Bypass:
  - Stimulus: write 0x7E to entry 1 and search 0x7E in the same cycle.
  - Expect: hit=1 next cycle when the macro is defined. Undefined: hit=0, then hit=1 on a repeat search.
